keypad_encoder: RTL and testbench

- Scans a 4-row x 5-column matrix keypad, debounces key presses, and encodes each press into a 5-bit key code with a one-cycle strobe.
- Output pair drives the calculator datapath key inputs directly: valid_input/input_value.
- Codes: digits 0-F = 5'h00-5'h0F; plus = 5'h10, minus = 5'h11, equal = 5'h12, clear = 5'h13.

---
 rtl/keypad_encoder.sv | 175 +++++++++++++++++
 tb/tb_keypad_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Matrix keypad scanner/encoder: drives one row low at a time, samples the
// synchronized columns once per dwell period, debounces press and release,
// and emits a one-cycle strobe with the 5-bit key code (row*5 + col).
module keypad_encoder #(
    parameter int unsigned SCAN_DIV = 4,  // cycles each row stays driven, >= 3
    parameter int unsigned DEBOUNCE = 3   // identical samples to accept press/release, >= 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [4:0] col_n,
    output logic [3:0] row_n,
    output logic       valid_input,
    output logic [4:0] input_value,
    output logic       key_held
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam logic [DivW-1:0] DwellLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntAccept = CntW'(DEBOUNCE);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      col_meta_q, col_meta_d;
    logic [4:0]      col_sync_q, col_sync_d;
    logic [DivW-1:0] dwell_q, dwell_d;
    logic [1:0]      row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      cand_q, cand_d;
    logic [4:0]      value_q, value_d;
    logic            held_q, held_d;

    logic            sample;
    logic [4:0]      col_low;
    logic            key_idle;
    logic            key_valid;
    logic [2:0]      col_idx;
    logic [4:0]      key_code;

    // Column synchronizer and free-running dwell counter; sampling happens on the last dwell cycle.
    always_comb begin
        col_meta_d = col_n;
        col_sync_d = col_meta_q;
        sample     = (dwell_q == DwellLast);
        dwell_d    = sample ? '0 : dwell_q + DivW'(1);
    end

    // Classify the synchronized sample: idle, exactly one column (valid), or multi (ignored).
    always_comb begin
        col_low   = ~col_sync_q;
        key_idle  = (col_low == 5'd0);
        key_valid = !key_idle && ((col_low & (col_low - 5'd1)) == 5'd0);
        case (col_low)
            5'b00001: col_idx = 3'd0;
            5'b00010: col_idx = 3'd1;
            5'b00100: col_idx = 3'd2;
            5'b01000: col_idx = 3'd3;
            5'b10000: col_idx = 3'd4;
            default:  col_idx = 3'd0;
        endcase
        key_code = ({3'b000, row_q} * 5'd5) + {2'b00, col_idx};
    end

    // Scan/debounce/emit/release next-state logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        value_d = value_q;
        held_d  = held_q;
        unique case (state_q)
            StScan: begin
                if (sample) begin
                    if (key_valid) begin
                        cand_d = key_code;
                        if (CntAccept == CntOne) begin
                            state_d = StEmit;
                            value_d = key_code;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StDebounce;
                            cnt_d   = CntOne;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            StDebounce: begin
                if (sample) begin
                    if (key_valid && (key_code == cand_q)) begin
                        if (cnt_q + CntOne == CntAccept) begin
                            state_d = StEmit;
                            value_d = cand_q;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end else begin
                        // Bounce or different key: abandon and move on.
                        state_d = StScan;
                        cnt_d   = '0;
                        row_d   = row_q + 2'd1;
                    end
                end
            end
            StEmit: begin
                state_d = StRelease;
                cnt_d   = '0;
            end
            StRelease: begin
                if (sample) begin
                    // Any non-idle sample, even a multi-press, restarts the release count.
                    if (key_idle) begin
                        if (cnt_q + CntOne == CntAccept) begin
                            state_d = StScan;
                            cnt_d   = '0;
                            held_d  = 1'b0;
                            row_d   = row_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StScan;
            col_meta_q <= '1;
            col_sync_q <= '1;
            dwell_q    <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            value_q    <= '0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_meta_q <= col_meta_d;
            col_sync_q <= col_sync_d;
            dwell_q    <= dwell_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            value_q    <= value_d;
            held_q     <= held_d;
        end
    end

    // Outputs: one-hot-low row drive, strobe only in the emit cycle.
    always_comb begin
        row_n       = ~(4'b0001 << row_q);
        valid_input = (state_q == StEmit);
        input_value = value_q;
        key_held    = held_q;
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural 4x5 key matrix.
module tb_keypad_encoder;

    logic        clk;
    logic        nrst;
    logic [4:0]  col_n;
    logic [3:0]  row_n;
    logic        valid_input;
    logic [4:0]  input_value;
    logic        key_held;

    logic [19:0] pressed;
    int          total;
    int          bad;
    int          strobe_cnt;

    keypad_encoder #(
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .col_n      (col_n),
        .row_n      (row_n),
        .valid_input(valid_input),
        .input_value(input_value),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 5'b11111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!row_n[r] && pressed[r*5+c]) col_n[c] = 1'b0;
            end
        end
    end

    // Strobe counter, sampled away from the active edge.
    always @(negedge clk) begin
        if (nrst === 1'b1 && valid_input === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the given row becomes driven.
    task automatic wait_row_start(input logic [3:0] rn);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = row_n;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (row_n == rn && prev != rn) found = 1'b1;
            prev = row_n;
        end
        chk("row_start_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_release(input logic [4:0] code);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!key_held) found = 1'b1;
        end
        chk("release_seen", 32'(found), 32'd1);
        chk("value_hold", 32'(input_value), 32'(code));
    endtask

    task automatic press_key(input int r, input int c, input logic [4:0] code);
        logic found;
        pressed = '0;
        pressed[r*5+c] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (valid_input) found = 1'b1;
        end
        chk("strobe_seen", 32'(found), 32'd1);
        chk("strobe_code", 32'(input_value), 32'(code));
        chk("held_at_strobe", 32'(key_held), 32'd1);
        @(negedge clk);
        chk("strobe_width", 32'(valid_input), 32'd0);
        pressed = '0;
        wait_release(code);
    endtask

    int          base;
    int          changes;
    int          hit_at;
    logic [3:0]  prev_row;
    logic        found;
    int          seq_r [11] = '{0, 0, 0, 3, 1, 0, 3, 1, 0, 3, 3};
    int          seq_c [11] = '{1, 0, 0, 1, 3, 0, 2, 1, 0, 3, 4};
    logic [4:0]  seq_k [11] = '{5'h01, 5'h00, 5'h00, 5'h10, 5'h08, 5'h00,
                                5'h11, 5'h06, 5'h00, 5'h12, 5'h13};

    initial begin
        total      = 0;
        bad        = 0;
        strobe_cnt = 0;
        pressed    = '0;
        nrst       = 1'b0;

        // Reset values.
        tick(3);
        chk("rst_row", 32'(row_n), 32'hE);
        chk("rst_valid", 32'(valid_input), 32'd0);
        chk("rst_value", 32'(input_value), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);

        // Idle rotation: four cycles per row, wrapping back to row 0.
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("idle_row", 32'(row_n), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
            chk("idle_valid", 32'(valid_input), 32'd0);
            @(negedge clk);
        end

        // Long hold on row1/col3: exactly one strobe, row frozen.
        base = strobe_cnt;
        pressed[8] = 1'b1;
        tick(200);
        chk("hold_strobes", 32'(strobe_cnt - base), 32'd1);
        chk("hold_value", 32'(input_value), 32'h08);
        chk("hold_held", 32'(key_held), 32'd1);
        chk("hold_row", 32'(row_n), 32'hD);
        pressed = '0;
        tick(8);
        chk("release_not_early", 32'(key_held), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!key_held) found = 1'b1;
        end
        chk("hold_release_seen", 32'(found), 32'd1);
        chk("resume_row2", 32'(row_n), 32'hB);

        // Bounce on row0/col1: one-sample press, then two-sample press; neither accepted.
        base = strobe_cnt;
        wait_row_start(4'hE);
        pressed[1] = 1'b1;
        tick(4);
        pressed = '0;
        tick(4);
        wait_row_start(4'hE);
        pressed[1] = 1'b1;
        tick(8);
        pressed = '0;
        tick(40);
        chk("bounce_no_strobe", 32'(strobe_cnt - base), 32'd0);
        press_key(0, 1, 5'h01);
        chk("bounce_then_one", 32'(strobe_cnt - base), 32'd1);

        // Two keys on row 2 together: ignored, rotation continues.
        base = strobe_cnt;
        pressed = '0;
        pressed[10] = 1'b1;
        pressed[12] = 1'b1;
        changes  = 0;
        prev_row = row_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_n != prev_row) changes++;
            prev_row = row_n;
        end
        pressed = '0;
        chk("multi_no_strobe", 32'(strobe_cnt - base), 32'd0);
        chk("multi_no_held", 32'(key_held), 32'd0);
        chk("multi_rotates", 32'(changes >= 9), 32'd1);

        // Calculator key sequence with releases in between.
        base = strobe_cnt;
        for (int k = 0; k < 11; k++) begin
            press_key(seq_r[k], seq_c[k], seq_k[k]);
        end
        tick(2);
        chk("seq_strobes", 32'(strobe_cnt - base), 32'd11);

        // Reset during debounce with count 2 on row2/col4, key still held afterwards.
        wait_row_start(4'hB);
        pressed[14] = 1'b1;
        tick(8);
        nrst = 1'b0;
        #1;
        chk("mid_rst_row", 32'(row_n), 32'hE);
        chk("mid_rst_valid", 32'(valid_input), 32'd0);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_value", 32'(input_value), 32'd0);
        @(negedge clk);
        nrst   = 1'b1;
        hit_at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (valid_input && hit_at < 0) hit_at = i;
        end
        chk("post_rst_latency", 32'(hit_at), 32'd20);
        chk("post_rst_value", 32'(input_value), 32'h0E);
        chk("post_rst_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_release(5'h0E);
        tick(2);
        chk("total_strobes", 32'(strobe_cnt), 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
